// File: rtl/lemming_world_pkg.sv
// Shared constants, clog2 helper and walker state encoding for the lemming world slice.
package lemming_world_pkg;

  localparam int          DEF_W            = 16;
  localparam logic [15:0] DEF_INIT_MAP     = 16'hFFFF;
  localparam int          DEF_INIT_POS     = 0;
  localparam int          DEF_STEP_DIV     = 4;
  localparam int          DEF_FALL_CYCLES  = 3;
  localparam int          DEF_DIG_CYCLES   = 5;
  localparam int          DEF_SPLAT_CYCLES = 20;

  // Encoding used by the walker FSM; kept here so bench checkers can decode it.
  typedef enum logic [2:0] {
    WALKER_LEFT   = 3'd0,
    WALKER_RIGHT  = 3'd1,
    WALKER_FALL_L = 3'd2,
    WALKER_FALL_R = 3'd3,
    WALKER_DIG_L  = 3'd4,
    WALKER_DIG_R  = 3'd5,
    WALKER_SPLAT  = 3'd6
  } walker_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/lemming_tick_div.sv
// Step divider: counts enabled cycles and pulses tick on every DIV-th one.
module lemming_tick_div
  import lemming_world_pkg::*;
#(
  parameter int DIV = DEF_STEP_DIV
) (
  input  logic clk,
  input  logic areset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = clog2(DIV) + 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(DIV - 1));

  // A dropped enable discards the partial count.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      cnt <= '0;
    end else if (clr || !en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/lemming_world.sv
// Terrain/environment model closing the loop around the lemming walker.
// Optional sticky splat detector enabled by defining LEMMING_WORLD_SPLAT_EN.
module lemming_world
  import lemming_world_pkg::*;
#(
  parameter int           W            = DEF_W,
  parameter logic [W-1:0] INIT_MAP     = DEF_INIT_MAP,
  parameter int           INIT_POS     = DEF_INIT_POS,
  parameter int           STEP_DIV     = DEF_STEP_DIV,
  parameter int           FALL_CYCLES  = DEF_FALL_CYCLES,
  parameter int           DIG_CYCLES   = DEF_DIG_CYCLES,
  parameter int           SPLAT_CYCLES = DEF_SPLAT_CYCLES
) (
  input  logic                clk,
  input  logic                areset,
  input  logic                walk_left,
  input  logic                walk_right,
  input  logic                aaah,
  input  logic                digging,
  input  logic                dig_req,
  input  logic                load,
  input  logic [W-1:0]        load_map,
  input  logic [clog2(W)-1:0] load_pos,
  output logic                ground,
  output logic                bump_left,
  output logic                bump_right,
  output logic                dig,
  output logic [clog2(W)-1:0] pos
`ifdef LEMMING_WORLD_SPLAT_EN
  ,
  output logic                splat
`endif
);

  localparam int PW = clog2(W);
  localparam int FW = clog2(FALL_CYCLES) + 1;
  localparam int DW = clog2(DIG_CYCLES) + 1;

  logic [W-1:0]  solid;
  logic [FW-1:0] fall_cnt;
  logic [DW-1:0] dig_cnt;
  logic          cur_solid;
  logic          step_en;
  logic          step_tick;
  logic          falling;
  logic          land;
  logic          dig_act;
  logic          dig_done;
  logic [PW-1:0] load_pos_c;

  assign cur_solid = solid[pos];
  assign step_en   = (walk_left ^ walk_right) && cur_solid;
  assign falling   = aaah && !cur_solid;
  assign land      = falling && (fall_cnt == FW'(FALL_CYCLES - 1));
  assign dig_act   = digging && cur_solid;
  assign dig_done  = dig_act && (dig_cnt == DW'(DIG_CYCLES - 1));

  assign load_pos_c = (int'(load_pos) >= W) ? PW'(W - 1) : load_pos;

  assign ground     = cur_solid;
  assign bump_left  = (pos == '0);
  assign bump_right = (pos == PW'(W - 1));

  lemming_tick_div #(.DIV(STEP_DIV)) u_step_div (
    .clk    (clk),
    .areset (areset),
    .en     (step_en),
    .clr    (load),
    .tick   (step_tick)
  );

  // Event priority: load, then landing, then dig completion, then step.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      solid    <= INIT_MAP;
      pos      <= PW'(INIT_POS);
      fall_cnt <= '0;
      dig_cnt  <= '0;
      dig      <= 1'b0;
    end else begin
      dig <= dig_req;
      if (load) begin
        solid    <= load_map;
        pos      <= load_pos_c;
        fall_cnt <= '0;
        dig_cnt  <= '0;
      end else begin
        fall_cnt <= (falling && !land) ? fall_cnt + FW'(1) : '0;
        dig_cnt  <= (dig_act && !dig_done) ? dig_cnt + DW'(1) : '0;
        if (land) begin
          solid[pos] <= 1'b1;
        end else if (dig_done) begin
          solid[pos] <= 1'b0;
        end else if (step_tick) begin
          if (walk_left && pos != '0) begin
            pos <= pos - PW'(1);
          end else if (walk_right && pos != PW'(W - 1)) begin
            pos <= pos + PW'(1);
          end
        end
      end
    end
  end

`ifdef LEMMING_WORLD_SPLAT_EN
  localparam int LW = clog2(SPLAT_CYCLES) + 1;

  logic [LW-1:0] fall_len;
  logic [LW-1:0] fall_len_nxt;

  // Fall length spans chained pits, so it follows aaah alone, not solid[pos].
  always_comb begin
    fall_len_nxt = '0;
    if (aaah) begin
      fall_len_nxt = (fall_len == LW'(SPLAT_CYCLES)) ? fall_len : fall_len + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      fall_len <= '0;
      splat    <= 1'b0;
    end else if (load) begin
      fall_len <= '0;
      splat    <= 1'b0;
    end else begin
      fall_len <= fall_len_nxt;
      if (fall_len_nxt == LW'(SPLAT_CYCLES)) begin
        splat <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/lemming_world.md
Name: lemming_world

Overview:
- Cycle-level terrain/environment model that drives the stimulus side of the lemming walker FSM: `ground`, `bump_left`, `bump_right`, `dig`.
- Consumes the walker's `walk_left`, `walk_right`, `aaah` and `digging` outputs.
- Tracks the lemming's column, moves it, fills pits on landing and removes terrain under a digging lemming.
- Closes the loop for self-checking system benches and the FPGA demo.

Parameters:
- W, 16: number of terrain columns, 2..64.
- INIT_MAP, 16'hFFFF: reset terrain bitmap; bit c = 1 means column c is solid.
- INIT_POS, 0: reset column of the lemming, < W.
- STEP_DIV, 4: clock cycles per one-column step, ≥ 1.
- FALL_CYCLES, 3: cycles of `aaah` before the lemming lands, ≥ 1.
- DIG_CYCLES, 5: consecutive `digging` cycles needed to remove one column, ≥ 1.
- SPLAT_CYCLES, 20: fall length threshold for the optional feature.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- areset  in  1  asynchronous, active-low reset.
- walk_left  in  1  lemming walking left.
- walk_right  in  1  lemming walking right.
- aaah  in  1  lemming falling.
- digging  in  1  lemming digging.
- dig_req  in  1  bench/user request to dig.
- load  in  1  synchronous terrain/position load strobe.
- load_map  in  W  terrain bitmap applied on `load`.
- load_pos  in  clog2(W)  column applied on `load`.
- ground  out  1  `solid[pos]`.
- bump_left  out  1  `pos == 0`.
- bump_right  out  1  `pos == W-1`.
- dig  out  1  `dig_req` delayed by one clock.
- pos  out  clog2(W)  current lemming column.

Behaviour:
- Reset (areset = 0, async):
  - solid = INIT_MAP, pos = INIT_POS.
  - step_cnt, fall_cnt, dig_cnt = 0; dig = 0.
  - Consequently ground = INIT_MAP[INIT_POS], bump_left = (INIT_POS == 0), bump_right = (INIT_POS == W-1).
- Outputs are pure decodes of registers; there is no combinational path from any input to any output.
- Priority each clock, highest first:
  1. `load`
  2. landing
  3. dig completion
  4. step
- Load:
  - solid ← load_map, pos ← load_pos.
  - All counters ← 0.
  - A load_pos ≥ W is clamped to W-1.
- Step counter:
  - Increments while (walk_left XOR walk_right) and ground.
  - Otherwise clears.
  - At STEP_DIV-1 it wraps to 0 and issues a step:
    - walk_left and pos > 0: pos − 1.
    - walk_right and pos < W-1: pos + 1.
    - At an edge: no move; the counter still wraps.
  - walk_left and walk_right both high: no step, counter clears.
- Fall:
  - While aaah and !solid[pos]: fall_cnt increments.
  - When fall_cnt == FALL_CYCLES-1: solid[pos] ← 1 (lands on the pit floor, which becomes the new surface) and fall_cnt ← 0.
  - aaah low, or solid[pos] = 1: fall_cnt ← 0.
  - pos never changes while falling.
- Dig:
  - While digging and solid[pos]: dig_cnt increments.
  - When dig_cnt == DIG_CYCLES-1: solid[pos] ← 0 and dig_cnt ← 0. ground drops the next cycle.
  - digging low: dig_cnt ← 0, with no partial credit kept.
- Landing and dig completion never coincide, because they require opposite solid[pos] values.
- areset mid-fall or mid-dig: all in-progress counts are discarded; terrain returns to INIT_MAP.
- Counter widths: clog2 of the largest threshold + 1. There is no overflow, because every counter clears at its threshold.

Optional Feature:
- Macro: LEMMING_WORLD_SPLAT_EN.
- Defined:
  - Adds output `splat` (1 bit) and a saturating counter `fall_len`.
  - `fall_len` counts consecutive aaah cycles, across landings of chained pits.
  - `splat` is set when `fall_len` reaches SPLAT_CYCLES and stays set (sticky) until areset or `load`.
  - Reset value of `splat` is 0.
- Undefined: no `splat` port and no `fall_len` logic; all other behaviour is identical.

Decomposition:
- Package lemming_world_pkg:
  - Default parameter constants.
  - A `clog2` function.
  - The walker state encoding, shared with the walker for bench checkers.
- Sub-module lemming_tick_div: the STEP_DIV counter with enable/clear and a tick output.
- Terrain, fall and dig logic stay in the top module.

Test Plan:
- Reset with INIT_POS = 0 → bump_left = 1, ground = 1, pos = 0. Hold walk_right 4·STEP_DIV cycles → pos = 4.
- pos = W-1, walk_right held 10 cycles → pos stays 15, bump_right = 1 throughout.
- load_map = 16'hFFEF, pos = 3, walk_right for STEP_DIV cycles → pos = 4, ground = 0. aaah for 3 cycles → solid[4] = 1, ground = 1.
- digging for 4 cycles, low 1 cycle, then high for 5 cycles → ground goes 0 only after the second run completes (terrain cleared on the 5th consecutive cycle, ground = 0 the next cycle).
- dig_req pulse at cycle t → dig = 1 exactly at t+1. load asserted in the same cycle as a dig completion → load wins.
- LEMMING_WORLD_SPLAT_EN defined: aaah held 20 cycles over chained pits → splat = 1, stays 1 after landing, cleared by load.
